dma_csr_bank: RTL and testbench

Multi-channel control/status register bank for the DMA engine, the parametrised successor of the single-channel CSR decoder. Presents a 32-bit memory-mapped slave with wait-request flow control and configurable read latency to the host bus. Holds a source/destination/length/control register set per channel and drives the channel movers with per-channel descriptors and one-cycle GO pulses. Collects sticky DONE/ERR status into a level interrupt.

---
 rtl/dma_csr_pkg.sv | 36 +++
 rtl/dma_csr_chan.sv | 92 +++++++++
 rtl/dma_csr_bank.sv | 146 ++++++++++++++
 tb/tb_dma_csr_bank.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_csr_pkg.sv
// Shared constants for the DMA CSR bank: FSM encodings, register word offsets,
// CTRL bit positions and the byte-enable merge helper.
package dma_csr_pkg;

   typedef logic [1:0] csr_state_t;

   localparam csr_state_t ST_IDLE     = 2'd0;
   localparam csr_state_t ST_WR_ACK   = 2'd1;
   localparam csr_state_t ST_RD_WAIT  = 2'd2;
   localparam csr_state_t ST_RD_VALID = 2'd3;

   // Word offsets within a channel window (byte address bits [3:2]).
   localparam logic [1:0] OFF_SRC  = 2'd0;
   localparam logic [1:0] OFF_DST  = 2'd1;
   localparam logic [1:0] OFF_LEN  = 2'd2;
   localparam logic [1:0] OFF_CTRL = 2'd3;

   localparam int CTRL_GO     = 0;
   localparam int CTRL_IRQ_EN = 1;
   localparam int CTRL_BUSY   = 8;
   localparam int CTRL_DONE   = 9;
   localparam int CTRL_ERR    = 10;

   localparam int CH_STRIDE = 16;

   function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  be);
      logic [31:0] res;
      for (int b = 0; b < 4; b++) begin
         res[b*8 +: 8] = be[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/dma_csr_chan.sv
// One channel's descriptor registers, sticky DONE/ERR status and GO pulse.
module dma_csr_chan
   import dma_csr_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        i_wr_en,
   input  logic [1:0]  i_off,
   input  logic [31:0] i_wr_data,
   input  logic [3:0]  i_wr_be,
   input  logic        i_busy,
   input  logic        i_done,
   input  logic        i_err,
   output logic [31:0] o_src,
   output logic [31:0] o_dst,
   output logic [31:0] o_len,
   output logic [31:0] o_rd_data,
   output logic        o_go,
   output logic        o_irq_req
);

   logic [31:0] r_src;
   logic [31:0] r_dst;
   logic [31:0] r_len;
   logic        r_irq_en;
   logic        r_done;
   logic        r_err;
   logic        r_go;

   logic        w_ctrl_wr;
   logic        w_clr_done;
   logic        w_clr_err;
   logic [31:0] w_ctrl;

   assign w_ctrl_wr  = i_wr_en && (i_off == OFF_CTRL);
   assign w_clr_done = w_ctrl_wr && i_wr_be[1] && i_wr_data[CTRL_DONE];
   assign w_clr_err  = w_ctrl_wr && i_wr_be[1] && i_wr_data[CTRL_ERR];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_src    <= '0;
         r_dst    <= '0;
         r_len    <= '0;
         r_irq_en <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
         r_go     <= 1'b0;
      end else begin
         r_go <= 1'b0;
         if (i_wr_en) begin
            case (i_off)
               OFF_SRC: r_src <= be_merge(r_src, i_wr_data, i_wr_be);
               OFF_DST: r_dst <= be_merge(r_dst, i_wr_data, i_wr_be);
               OFF_LEN: r_len <= be_merge(r_len, i_wr_data, i_wr_be);
               default: begin
                  if (i_wr_be[0]) begin
                     r_irq_en <= i_wr_data[CTRL_IRQ_EN];
                     r_go     <= i_wr_data[CTRL_GO] & ~i_busy;
                  end
               end
            endcase
         end
         // A new status pulse beats a simultaneous W1C.
         r_done <= i_done | (r_done & ~w_clr_done);
         r_err  <= i_err  | (r_err  & ~w_clr_err);
      end
   end

   always_comb begin
      w_ctrl              = '0;
      w_ctrl[CTRL_IRQ_EN] = r_irq_en;
      w_ctrl[CTRL_BUSY]   = i_busy;
      w_ctrl[CTRL_DONE]   = r_done;
      w_ctrl[CTRL_ERR]    = r_err;
   end

   always_comb begin
      case (i_off)
         OFF_SRC: o_rd_data = r_src;
         OFF_DST: o_rd_data = r_dst;
         OFF_LEN: o_rd_data = r_len;
         default: o_rd_data = w_ctrl;
      endcase
   end

   assign o_src     = r_src;
   assign o_dst     = r_dst;
   assign o_len     = r_len;
   assign o_go      = r_go;
   assign o_irq_req = r_irq_en & (r_done | r_err);

endmodule

// File: rtl/dma_csr_bank.sv
// Multi-channel DMA CSR bank: bus handshake FSM, channel decode, read mux, irq.
// state       | meaning
// ST_IDLE     | waiting for a request, write has priority
// ST_WR_ACK   | write accepted, registers update on exit
// ST_RD_WAIT  | read wait counter running down
// ST_RD_VALID | read accepted, data valid on csr_rd_data_o
module dma_csr_bank
   import dma_csr_pkg::*;
#(
   parameter  int NUM_CH  = 4,
   parameter  int DATA_W  = 32,
   parameter  int RD_WAIT = 2,
   localparam int ADDR_W  = $clog2(NUM_CH) + 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     csr_wr_i,
   input  logic                     csr_rd_i,
   input  logic [ADDR_W-1:0]        csr_addr_i,
   input  logic [DATA_W-1:0]        csr_wr_data_i,
   input  logic [DATA_W/8-1:0]      csr_be_i,
   output logic                     csr_wait_rq_o,
   output logic [DATA_W-1:0]        csr_rd_data_o,
   input  logic [NUM_CH-1:0]        ch_busy_i,
   input  logic [NUM_CH-1:0]        ch_done_i,
   input  logic [NUM_CH-1:0]        ch_err_i,
   output logic [NUM_CH*DATA_W-1:0] ch_src_o,
   output logic [NUM_CH*DATA_W-1:0] ch_dst_o,
   output logic [NUM_CH*DATA_W-1:0] ch_len_o,
   output logic [NUM_CH-1:0]        ch_go_o,
   output logic                     irq_o
);

   localparam int         CH_BITS   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [2:0] WAIT_LOAD = (RD_WAIT > 0) ? 3'(RD_WAIT - 1) : 3'd0;

   csr_state_t          r_state;
   csr_state_t          w_state_nxt;
   logic [2:0]          r_wait_cnt;
   logic [DATA_W-1:0]   r_rd_data;
   logic                r_irq;
   logic                w_rd_load;
   logic [CH_BITS-1:0]  w_ch_idx;
   logic [1:0]          w_off;
   logic [NUM_CH-1:0]   w_wr_en;
   logic [NUM_CH-1:0]   w_irq_req;
   logic [DATA_W-1:0]   w_chan_rd [NUM_CH];
   logic [DATA_W-1:0]   w_rd_mux;
   logic                w_addr_unused;

   assign w_off         = csr_addr_i[3:2];
   assign w_addr_unused = ^csr_addr_i[1:0];

   generate
      if (NUM_CH > 1) begin : g_idx
         assign w_ch_idx = csr_addr_i[ADDR_W-1:4];
      end else begin : g_idx_one
         assign w_ch_idx = '0;
      end
   endgenerate

   always_comb begin
      w_state_nxt = r_state;
      w_rd_load   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (csr_wr_i) begin
               w_state_nxt = ST_WR_ACK;
            end else if (csr_rd_i) begin
               if (RD_WAIT == 0) begin
                  w_state_nxt = ST_RD_VALID;
                  w_rd_load   = 1'b1;
               end else begin
                  w_state_nxt = ST_RD_WAIT;
               end
            end
         end
         ST_WR_ACK: w_state_nxt = ST_IDLE;
         ST_RD_WAIT: begin
            if (r_wait_cnt == 3'd0) begin
               w_state_nxt = ST_RD_VALID;
               w_rd_load   = 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_wait_cnt <= 3'd0;
         r_rd_data  <= '0;
         r_irq      <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == ST_IDLE) begin
            r_wait_cnt <= WAIT_LOAD;
         end else if (r_state == ST_RD_WAIT && r_wait_cnt != 3'd0) begin
            r_wait_cnt <= r_wait_cnt - 3'd1;
         end
         // Holding zero outside RD_VALID keeps the data bus quiet between reads.
         r_rd_data <= w_rd_load ? w_rd_mux : '0;
         r_irq     <= |w_irq_req;
      end
   end

   // Unmapped channel indices match no slot: reads give 0, writes are dropped.
   always_comb begin
      w_rd_mux = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (w_ch_idx == CH_BITS'(i)) begin
            w_rd_mux = w_chan_rd[i];
         end
      end
   end

   generate
      for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
         assign w_wr_en[i] = (r_state == ST_WR_ACK) && (w_ch_idx == CH_BITS'(i));

         dma_csr_chan u_chan (
            .clk       (clk),
            .reset     (reset),
            .i_wr_en   (w_wr_en[i]),
            .i_off     (w_off),
            .i_wr_data (csr_wr_data_i),
            .i_wr_be   (csr_be_i),
            .i_busy    (ch_busy_i[i]),
            .i_done    (ch_done_i[i]),
            .i_err     (ch_err_i[i]),
            .o_src     (ch_src_o[i*DATA_W +: DATA_W]),
            .o_dst     (ch_dst_o[i*DATA_W +: DATA_W]),
            .o_len     (ch_len_o[i*DATA_W +: DATA_W]),
            .o_rd_data (w_chan_rd[i]),
            .o_go      (ch_go_o[i]),
            .o_irq_req (w_irq_req[i])
         );
      end
   endgenerate

   assign csr_wait_rq_o = !((r_state == ST_WR_ACK) || (r_state == ST_RD_VALID));
   assign csr_rd_data_o = r_rd_data;
   assign irq_o         = r_irq;

endmodule

// File: tb/tb_dma_csr_bank.sv
// Bench for dma_csr_bank: a 4-channel and a 3-channel instance share one bus;
// the 3-channel copy exposes the unmapped-window behaviour on channel 3 addresses.
module tb_dma_csr_bank;

   localparam int RD_WAIT = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        csr_wr_i, csr_rd_i;
   logic [5:0]  csr_addr_i;
   logic [31:0] csr_wr_data_i;
   logic [3:0]  csr_be_i;
   logic [3:0]  ch_busy_i, ch_done_i, ch_err_i;

   logic         csr_wait_rq_o, irq_o;
   logic [31:0]  csr_rd_data_o;
   logic [127:0] ch_src_o, ch_dst_o, ch_len_o;
   logic [3:0]   ch_go_o;

   logic         wait3, irq3;
   logic [31:0]  rd_data3;
   logic [95:0]  src3, dst3, len3;
   logic [2:0]   go3;

   dma_csr_bank #(.NUM_CH(4), .DATA_W(32), .RD_WAIT(RD_WAIT)) u_dut (
      .clk(clk), .reset(reset), .csr_wr_i(csr_wr_i), .csr_rd_i(csr_rd_i),
      .csr_addr_i(csr_addr_i), .csr_wr_data_i(csr_wr_data_i), .csr_be_i(csr_be_i),
      .csr_wait_rq_o(csr_wait_rq_o), .csr_rd_data_o(csr_rd_data_o),
      .ch_busy_i(ch_busy_i), .ch_done_i(ch_done_i), .ch_err_i(ch_err_i),
      .ch_src_o(ch_src_o), .ch_dst_o(ch_dst_o), .ch_len_o(ch_len_o),
      .ch_go_o(ch_go_o), .irq_o(irq_o));

   dma_csr_bank #(.NUM_CH(3), .DATA_W(32), .RD_WAIT(RD_WAIT)) u_dut3 (
      .clk(clk), .reset(reset), .csr_wr_i(csr_wr_i), .csr_rd_i(csr_rd_i),
      .csr_addr_i(csr_addr_i), .csr_wr_data_i(csr_wr_data_i), .csr_be_i(csr_be_i),
      .csr_wait_rq_o(wait3), .csr_rd_data_o(rd_data3),
      .ch_busy_i(ch_busy_i[2:0]), .ch_done_i(ch_done_i[2:0]), .ch_err_i(ch_err_i[2:0]),
      .ch_src_o(src3), .ch_dst_o(dst3), .ch_len_o(len3),
      .ch_go_o(go3), .irq_o(irq3));

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   logic [31:0] m_src [4];
   logic [31:0] m_dst [4];
   logic [31:0] m_len [4];
   logic        m_ie [4];
   logic        m_done [4];
   logic        m_err [4];

   logic [63:0] sb [$];
   logic [63:0] sb_e;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = o;
      for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = n[b*8 +: 8];
      return r;
   endfunction

   function automatic logic [31:0] exp_rd(input logic [5:0] a);
      int ch;
      ch = int'(a[5:4]);
      case (a[3:2])
         2'd0:    return m_src[ch];
         2'd1:    return m_dst[ch];
         2'd2:    return m_len[ch];
         default: return {21'd0, m_err[ch], m_done[ch], ch_busy_i[ch], 6'd0, m_ie[ch], 1'b0};
      endcase
   endfunction

   function automatic logic model_irq(input int n);
      logic r;
      r = 1'b0;
      for (int i = 0; i < n; i++) r |= m_ie[i] & (m_done[i] | m_err[i]);
      return r;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_src[i] = '0; m_dst[i] = '0; m_len[i] = '0;
         m_ie[i] = 1'b0; m_done[i] = 1'b0; m_err[i] = 1'b0;
      end
   endtask

   task automatic check_desc();
      for (int i = 0; i < 4; i++) begin
         check("src", ch_src_o[i*32 +: 32], m_src[i]);
         check("dst", ch_dst_o[i*32 +: 32], m_dst[i]);
         check("len", ch_len_o[i*32 +: 32], m_len[i]);
      end
      for (int i = 0; i < 3; i++) begin
         check("src3", src3[i*32 +: 32], m_src[i]);
         check("dst3", dst3[i*32 +: 32], m_dst[i]);
         check("len3", len3[i*32 +: 32], m_len[i]);
      end
   endtask

   // Read-data scoreboard: expectations are popped when a read is accepted.
   always @(negedge clk) begin
      if (!reset && !csr_wait_rq_o && csr_rd_i && !csr_wr_i) begin
         if (sb.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
         end else begin
            sb_e = sb.pop_front();
            check("rd_data", csr_rd_data_o, sb_e[63:32]);
            check("rd_data3", rd_data3, sb_e[31:0]);
            check("rd_wait3", {31'd0, wait3}, 32'd0);
         end
      end
   end

   task automatic bus_wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] be,
                         input int pulse_ch);
      int n;
      int ch;
      logic [3:0] go_exp;
      ch = int'(a[5:4]);
      @(negedge clk);
      csr_wr_i = 1'b1; csr_addr_i = a; csr_wr_data_i = d; csr_be_i = be;
      n = 0;
      do begin @(negedge clk); n++; end while (csr_wait_rq_o && n < 20);
      check("wr_lat", n, 1);
      if (pulse_ch >= 0) ch_done_i[pulse_ch] = 1'b1;
      go_exp = '0;
      if (a[3:2] == 2'd3 && be[0] && d[0] && !ch_busy_i[ch]) go_exp[ch] = 1'b1;
      @(posedge clk); #1;
      csr_wr_i = 1'b0; ch_done_i = '0;
      case (a[3:2])
         2'd0: m_src[ch] = merge(m_src[ch], d, be);
         2'd1: m_dst[ch] = merge(m_dst[ch], d, be);
         2'd2: m_len[ch] = merge(m_len[ch], d, be);
         default: begin
            if (be[0]) m_ie[ch] = d[1];
            if (be[1] && d[9])  m_done[ch] = 1'b0;
            if (be[1] && d[10]) m_err[ch]  = 1'b0;
         end
      endcase
      if (pulse_ch >= 0) m_done[pulse_ch] = 1'b1;
      @(negedge clk);
      check("go_pulse", {28'd0, ch_go_o}, {28'd0, go_exp});
      check("go_pulse3", {29'd0, go3}, {29'd0, go_exp[2:0]});
      @(negedge clk);
      check("go_clear", {28'd0, ch_go_o}, 32'd0);
   endtask

   task automatic bus_rd(input logic [5:0] a);
      int n;
      logic [31:0] e4;
      e4 = exp_rd(a);
      sb.push_back({e4, (a[5:4] == 2'd3) ? 32'd0 : e4});
      @(negedge clk);
      csr_rd_i = 1'b1; csr_addr_i = a;
      n = 0;
      do begin @(negedge clk); n++; end while (csr_wait_rq_o && n < 20);
      check("rd_lat", n, 1 + RD_WAIT);
      @(posedge clk); #1;
      csr_rd_i = 1'b0;
   endtask

   task automatic pulse_stat(input int ch, input bit is_err);
      logic i4, i3;
      @(negedge clk);
      i4 = model_irq(4); i3 = model_irq(3);
      if (is_err) begin ch_err_i[ch] = 1'b1; m_err[ch] = 1'b1; end
      else begin ch_done_i[ch] = 1'b1; m_done[ch] = 1'b1; end
      @(negedge clk);
      ch_err_i = '0; ch_done_i = '0;
      check("irq_t1", {31'd0, irq_o}, {31'd0, i4});
      check("irq3_t1", {31'd0, irq3}, {31'd0, i3});
      @(negedge clk);
      check("irq_t2", {31'd0, irq_o}, {31'd0, model_irq(4)});
      check("irq3_t2", {31'd0, irq3}, {31'd0, model_irq(3)});
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog expired got running expected finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [31:0] v;
      reset = 1'b1; csr_wr_i = 0; csr_rd_i = 0; csr_addr_i = '0;
      csr_wr_data_i = '0; csr_be_i = '0; ch_busy_i = '0; ch_done_i = '0; ch_err_i = '0;
      model_reset();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_wait", {31'd0, csr_wait_rq_o}, 32'd1);
      check("rst_rdata", csr_rd_data_o, 32'd0);
      check("rst_go", {28'd0, ch_go_o}, 32'd0);
      check("rst_irq", {31'd0, irq_o}, 32'd0);
      check_desc();
      bus_rd(6'h1C);

      // Byte-enable merge on channel 2 DST.
      bus_wr(6'h24, 32'h1122_3344, 4'hF, -1);
      bus_wr(6'h24, 32'hDEAD_BEEF, 4'b0011, -1);
      check("dst2_merge", ch_dst_o[64 +: 32], 32'h1122_BEEF);
      bus_rd(6'h24);

      for (int i = 0; i < 4; i++) begin
         bus_wr(6'(i*16 + 0), $urandom, 4'hF, -1);
         bus_wr(6'(i*16 + 8), $urandom, 4'($urandom_range(1, 15)), -1);
      end
      for (int i = 0; i < 4; i++) begin
         bus_rd(6'(i*16 + 0));
         bus_rd(6'(i*16 + 8));
      end
      check_desc();

      // GO pulses, and GO suppressed while busy.
      bus_wr(6'h1C, 32'h3, 4'h1, -1);
      ch_busy_i[1] = 1'b1;
      bus_wr(6'h1C, 32'h3, 4'h1, -1);
      bus_rd(6'h1C);
      ch_busy_i[1] = 1'b0;
      bus_wr(6'h3C, 32'h1, 4'h1, -1);

      // DONE/ERR stickiness, W1C, set-beats-clear, irq.
      bus_wr(6'h3C, 32'h2, 4'h1, -1);
      pulse_stat(3, 1'b0);
      bus_rd(6'h3C);
      bus_wr(6'h3C, 32'h202, 4'b0011, -1);
      check("irq_after_clr", {31'd0, irq_o}, {31'd0, model_irq(4)});
      bus_rd(6'h3C);
      pulse_stat(3, 1'b0);
      bus_wr(6'h3C, 32'h202, 4'b0011, 3);
      check("irq_set_wins", {31'd0, irq_o}, {31'd0, model_irq(4)});
      bus_rd(6'h3C);
      pulse_stat(0, 1'b1);
      bus_rd(6'h0C);
      bus_wr(6'h0C, 32'h400, 4'b0010, -1);
      bus_rd(6'h0C);
      bus_wr(6'h0C, 32'h2, 4'h1, -1);
      pulse_stat(0, 1'b0);

      // Write and read requested together: write first, read after an idle cycle.
      @(negedge clk);
      csr_wr_i = 1'b1; csr_rd_i = 1'b1; csr_addr_i = 6'h28;
      csr_wr_data_i = 32'hA5A5_0F0F; csr_be_i = 4'hF;
      n = 0;
      do begin @(negedge clk); n++; end while (csr_wait_rq_o && n < 20);
      check("both_wr_lat", n, 1);
      @(posedge clk); #1;
      csr_wr_i = 1'b0;
      m_len[2] = 32'hA5A5_0F0F;
      sb.push_back({m_len[2], m_len[2]});
      do begin @(negedge clk); n++; end while (csr_wait_rq_o && n < 40);
      check("both_rd_lat", n, 2 + 1 + RD_WAIT);
      @(posedge clk); #1;
      csr_rd_i = 1'b0;

      // Channel 3 window is unmapped in the 3-channel copy.
      bus_wr(6'h30, 32'hCAFE_F00D, 4'hF, -1);
      bus_rd(6'h30);
      bus_rd(6'h3C);
      check_desc();

      // Reset in the middle of a read.
      v = ch_dst_o[64 +: 32];
      check("pre_rst_dst2", v, m_dst[2]);
      @(negedge clk);
      csr_rd_i = 1'b1; csr_addr_i = 6'h24;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("midrst_wait", {31'd0, csr_wait_rq_o}, 32'd1);
      check("midrst_rdata", csr_rd_data_o, 32'd0);
      check("midrst_irq", {31'd0, irq_o}, 32'd0);
      csr_rd_i = 1'b0;
      model_reset();
      check_desc();
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("post_rst_wait", {31'd0, csr_wait_rq_o}, 32'd1);
      check("post_rst_go", {28'd0, ch_go_o}, 32'd0);
      bus_rd(6'h24);
      bus_rd(6'h3C);

      check("sb_drained", sb.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
